// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute controller for the 16-bit CPU.
// Fetches instructions over a RAM req/ack handshake into an instruction
// register, owns the 8-bit PC, and sequences register-file / ALU / RAM controls.
//
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-high reset
//   start               - one-cycle pulse, starts execution from PC_RESET (IDLE/HALT only)
//   ram_req, ram_addr   - RAM read request and address (address stable while requesting)
//   ram_ack, ram_rdata  - RAM read data valid strobe and data
//   alu_code            - ALU operation select
//   reg_read, reg_write - register file read / write enables
//   wb_sel              - writeback source: 0 ALU result, 1 load_data
//   reg1, reg2          - destination/first source and second source register
//   load_data           - RAM data captured for LOAD writeback
//   branch_check        - ALU compare result for the branch in EXEC
//   pc, ir              - program counter and instruction register
//   halted, fault       - halt flag; fault code 00 none, 01 illegal opcode, 10 RAM timeout
//   retired             - retired instruction count (wraps)
module cpu_sequencer #(
  parameter logic [7:0]  PC_RESET    = 8'h00,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ram_req,
  output logic [7:0]  ram_addr,
  input  logic        ram_ack,
  input  logic [15:0] ram_rdata,
  output logic [3:0]  alu_code,
  output logic        reg_read,
  output logic        reg_write,
  output logic        wb_sel,
  output logic [1:0]  reg1,
  output logic [1:0]  reg2,
  output logic [15:0] load_data,
  input  logic        branch_check,
  output logic [7:0]  pc,
  output logic [15:0] ir,
  output logic        halted,
  output logic [1:0]  fault,
  output logic [15:0] retired
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_LOAD = 4'b1000;
  localparam logic [3:0] OP_JUMP = 4'b1100;

  localparam logic [3:0] ALU_ADD = 4'b1000;
  localparam logic [3:0] ALU_SUB = 4'b0100;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t state, state_next;

  logic [TW-1:0] tcnt;
  logic          tcnt_last;

  logic [3:0] opcode;
  logic [1:0] rs1, rs2;
  logic [7:0] adr;
  logic       op_alu, op_branch;

  // Internal datapath strobes produced by the FSM decode
  logic fetch_done, mem_done, retire, pc_load, restart, set_illegal, set_timeout;

  assign opcode    = ir[15:12];
  assign rs1       = ir[11:10];
  assign rs2       = ir[9:8];
  assign adr       = ir[7:0];
  assign op_alu    = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign op_branch = (opcode[3:2] == 2'b11) && (opcode[1:0] != 2'b00);
  // Last request cycle allowed before a missing ack becomes a fault
  assign tcnt_last = (tcnt == TW'(ACK_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and Moore control decode
  always_comb begin
    state_next  = state;
    ram_req     = 1'b0;
    ram_addr    = 8'h00;
    alu_code    = 4'h0;
    reg_read    = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = 1'b0;
    reg1        = 2'b00;
    reg2        = 2'b00;
    halted      = 1'b0;
    fetch_done  = 1'b0;
    mem_done    = 1'b0;
    retire      = 1'b0;
    pc_load     = 1'b0;
    restart     = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          restart    = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        ram_req  = 1'b1;
        ram_addr = pc;
        // Ack on the final allowed cycle still completes the fetch
        if (ram_ack) begin
          fetch_done = 1'b1;
          state_next = S_DECODE;
        end else if (tcnt_last) begin
          set_timeout = 1'b1;
          state_next  = S_HALT;
        end
      end
      S_DECODE: begin
        if (op_alu || op_branch) begin
          state_next = S_EXEC;
        end else if (opcode == OP_LOAD) begin
          state_next = S_MEM;
        end else if (opcode == OP_JUMP) begin
          pc_load    = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
        end else begin
          set_illegal = 1'b1;
          state_next  = S_HALT;
        end
      end
      S_EXEC: begin
        reg_read   = 1'b1;
        reg1       = rs1;
        reg2       = rs2;
        retire     = 1'b1;
        state_next = S_FETCH;
        if (op_branch) begin
          alu_code = opcode;
          pc_load  = branch_check;
        end else begin
          alu_code  = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
          reg_write = 1'b1;
        end
      end
      S_MEM: begin
        ram_req  = 1'b1;
        ram_addr = adr;
        if (ram_ack) begin
          mem_done   = 1'b1;
          state_next = S_WB;
        end else if (tcnt_last) begin
          set_timeout = 1'b1;
          state_next  = S_HALT;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        wb_sel     = 1'b1;
        reg1       = rs1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) begin
          restart    = 1'b1;
          state_next = S_FETCH;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // PC, IR, load data, retire count, fault code and ack timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= PC_RESET;
      ir        <= 16'h0000;
      load_data <= 16'h0000;
      retired   <= 16'h0000;
      fault     <= FAULT_NONE;
      tcnt      <= '0;
    end else begin
      if (restart)         pc <= PC_RESET;
      else if (fetch_done) pc <= pc + 8'd1;
      else if (pc_load)    pc <= adr;

      if (fetch_done) ir        <= ram_rdata;
      if (mem_done)   load_data <= ram_rdata;

      if (restart)     retired <= 16'h0000;
      else if (retire) retired <= retired + 16'd1;

      if (restart)          fault <= FAULT_NONE;
      else if (set_illegal) fault <= FAULT_ILLEGAL;
      else if (set_timeout) fault <= FAULT_TIMEOUT;

      // Request states are always separated by a non-request state, so
      // clearing outside a pending request equals clearing on entry.
      if (ram_req && !ram_ack) tcnt <= tcnt + TW'(1);
      else                     tcnt <= '0;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a RAM model with per-address ack delay,
// expected RAM transfer addresses and datapath control cycles queued by the
// stimulus and checked by an independent monitor, plus direct status checks.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        ram_req;
  logic [7:0]  ram_addr;
  logic        ram_ack;
  logic [15:0] ram_rdata;
  logic [3:0]  alu_code;
  logic        reg_read;
  logic        reg_write;
  logic        wb_sel;
  logic [1:0]  reg1;
  logic [1:0]  reg2;
  logic [15:0] load_data;
  logic        branch_check;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        halted;
  logic [1:0]  fault;
  logic [15:0] retired;

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_req(ram_req), .ram_addr(ram_addr), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .alu_code(alu_code), .reg_read(reg_read), .reg_write(reg_write), .wb_sel(wb_sel),
    .reg1(reg1), .reg2(reg2), .load_data(load_data), .branch_check(branch_check),
    .pc(pc), .ir(ir), .halted(halted), .fault(fault), .retired(retired)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem [256];
  int          delay_of [256];
  bit          never_ack = 1'b0;
  bit          bq [$];
  logic [7:0]  exp_addr [$];
  logic [26:0] exp_ctl [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [26:0] ctl(input logic [3:0] a, input logic rr, input logic rw,
                                      input logic wb, input logic [1:0] r1, input logic [1:0] r2,
                                      input logic [15:0] ld);
    return {a, rr, rw, wb, r1, r2, ld};
  endfunction

  // RAM and branch-compare responder, driven just after each rising edge
  initial begin : ram_model
    int wcnt;
    wcnt = 0;
    ram_ack = 1'b0;
    ram_rdata = 16'h0000;
    branch_check = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (ram_req && !never_ack && wcnt >= delay_of[ram_addr]) begin
        ram_ack   = 1'b1;
        ram_rdata = mem[ram_addr];
        wcnt      = 0;
      end else begin
        ram_ack   = 1'b0;
        ram_rdata = 16'h0000;
        wcnt      = ram_req ? wcnt + 1 : 0;
      end
      if (reg_read && alu_code[3:2] == 2'b11 && bq.size() > 0) branch_check = bq.pop_front();
      else branch_check = 1'b0;
    end
  end

  // Monitor: RAM transfers and datapath control cycles against the queues
  initial begin : monitor
    logic       prev_req;
    logic [7:0] prev_addr;
    logic [7:0] ea;
    logic [26:0] ec;
    prev_req = 1'b0;
    prev_addr = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
      end else begin
        if (ram_req && prev_req) check("addr_stable", 32'(ram_addr), 32'(prev_addr));
        if (ram_req && ram_ack) begin
          if (exp_addr.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL ram_xfer: unexpected transfer at addr %0h (t=%0t)", ram_addr, $time);
          end else begin
            ea = exp_addr.pop_front();
            check("ram_xfer_addr", 32'(ram_addr), 32'(ea));
          end
        end
        if (reg_read || reg_write) begin
          if (exp_ctl.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL ctl_cycle: unexpected control cycle alu=%0h (t=%0t)", alu_code, $time);
          end else begin
            ec = exp_ctl.pop_front();
            check("ctl_cycle", 32'({alu_code, reg_read, reg_write, wb_sel, reg1, reg2,
                                    (wb_sel ? load_data : 16'h0000)}), 32'(ec));
          end
        end
        prev_req  = ram_req && !ram_ack;
        prev_addr = ram_addr;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic wait_retired(input logic [15:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (retired == target) break;
    end
    check("wait_retired", 32'(retired), 32'(target));
  endtask

  task automatic wait_halted(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    check("wait_halted", 32'(halted), 32'd1);
  endtask

  initial begin : stim
    int req_cycles;
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'h0000;
      delay_of[i] = 0;
    end
    repeat (3) @(negedge clk);

    check("rst_ram_req", 32'(ram_req), 32'd0);
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_ir", 32'(ir), 32'h0000);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_load_data", 32'(load_data), 32'h0000);
    check("rst_reg_write", 32'(reg_write), 32'd0);
    rst = 1'b0;

    // Program: ADD, LOAD (slow MEM ack), taken branch, not-taken branch, JUMP, SUB at FF
    mem[8'h00] = 16'h0600;
    mem[8'h01] = 16'h8C42;
    mem[8'h42] = 16'hBEEF;
    delay_of[8'h42] = 3;
    mem[8'h02] = 16'hD47A;
    mem[8'h7A] = 16'hD47A;
    mem[8'h7B] = 16'hC0FF;
    mem[8'hFF] = 16'h4E00;
    exp_addr = '{8'h00, 8'h01, 8'h42, 8'h02, 8'h7A, 8'h7B, 8'hFF, 8'h00};
    exp_ctl.push_back(ctl(4'b1000, 1'b1, 1'b1, 1'b0, 2'd1, 2'd2, 16'h0000));
    exp_ctl.push_back(ctl(4'b0000, 1'b0, 1'b1, 1'b1, 2'd3, 2'd0, 16'hBEEF));
    exp_ctl.push_back(ctl(4'b1101, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 16'h0000));
    exp_ctl.push_back(ctl(4'b1101, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 16'h0000));
    exp_ctl.push_back(ctl(4'b0100, 1'b1, 1'b1, 1'b0, 2'd3, 2'd2, 16'h0000));
    bq = '{1'b1, 1'b0};

    pulse_start();
    wait_retired(16'd1, 20);
    check("add_ir", 32'(ir), 32'h0600);
    check("add_pc", 32'(pc), 32'h01);
    // Second visit to 00 (after PC wraps from FF) finds an illegal opcode
    mem[8'h00] = 16'h2000;
    // start while running must be ignored
    pulse_start();

    wait_halted(300);
    check("illegal_fault", 32'(fault), 32'h1);
    check("illegal_retired", 32'(retired), 32'd6);
    check("illegal_pc", 32'(pc), 32'h01);
    check("illegal_ir", 32'(ir), 32'h2000);

    // RAM that never acks: request held for exactly ACK_TIMEOUT cycles
    never_ack = 1'b1;
    pulse_start();
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (halted) break;
      if (ram_req) req_cycles++;
    end
    check("timeout_req_cycles", 32'(req_cycles), 32'd16);
    check("timeout_halted", 32'(halted), 32'd1);
    check("timeout_fault", 32'(fault), 32'h2);
    check("timeout_retired", 32'(retired), 32'd0);
    check("timeout_pc", 32'(pc), 32'h00);
    check("timeout_req_low", 32'(ram_req), 32'd0);

    // Restart from HALT clears the fault and fetches from 00
    never_ack = 1'b0;
    exp_addr.push_back(8'h00);
    pulse_start();
    @(negedge clk);
    check("restart_fault", 32'(fault), 32'h0);
    check("restart_req", 32'(ram_req), 32'd1);
    wait_halted(50);
    check("restart_fault_after", 32'(fault), 32'h1);
    check("restart_retired", 32'(retired), 32'd0);

    // Reset during the MEM wait, on the cycle the ack arrives
    mem[8'h00] = 16'h8C42;
    exp_addr.push_back(8'h00);
    exp_addr.push_back(8'h42);
    pulse_start();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ram_req && ram_ack && ram_addr == 8'h42) break;
    end
    check("mem_ack_seen", 32'(ram_ack && ram_addr == 8'h42), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mrst_ram_req", 32'(ram_req), 32'd0);
    check("mrst_ram_addr", 32'(ram_addr), 32'h00);
    check("mrst_load_data", 32'(load_data), 32'h0000);
    check("mrst_ir", 32'(ir), 32'h0000);
    check("mrst_pc", 32'(pc), 32'h00);
    check("mrst_halted", 32'(halted), 32'd0);
    check("mrst_fault", 32'(fault), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_ram_req", 32'(ram_req), 32'd0);
    check("idle_load_data", 32'(load_data), 32'h0000);
    check("idle_halted", 32'(halted), 32'd0);
    check("idle_reg_write", 32'(reg_write), 32'd0);

    check("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
    check("ctl_queue_drained", 32'(exp_ctl.size()), 32'd0);
    check("branch_queue_drained", 32'(bq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
